// File: rtl/byte_uart_tx_if.sv
// Byte-stream handshake between the upstream serializer and the UART
// transmitter: data and strobe go in, FIFO status flags come back.
interface byte_uart_tx_if;
    logic [7:0] din;
    logic       din_valid;
    logic       full;
    logic       empty;
    logic       overflow;

    modport master (
        output din,
        output din_valid,
        input  full,
        input  empty,
        input  overflow
    );

    modport slave (
        input  din,
        input  din_valid,
        output full,
        output empty,
        output overflow
    );
endinterface

// File: rtl/byte_uart_tx.sv
// Byte UART transmitter: buffers incoming bytes in a small synchronous FIFO
// and sends each one as an 8N1 frame (start, 8 data bits LSB first, stop).
module byte_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_AW      = 3
) (
    input  logic           pclk,
    input  logic           rst,
    byte_uart_tx_if.slave  bus,
    output logic           busy,
    output logic           txd
);

    localparam int          DEPTH     = 1 << FIFO_AW;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]       mem_q [DEPTH];
    logic [FIFO_AW:0] wrPtr_q;
    logic [FIFO_AW:0] rdPtr_q;
    logic             overflow_q;
    logic             fifoFull;
    logic             fifoEmpty;
    logic             push;
    logic             pop;
    logic             baudDone;

    state_t      state_q,   state_d;
    logic [15:0] baudCnt_q, baudCnt_d;
    logic [2:0]  bitIdx_q,  bitIdx_d;
    logic [7:0]  shift_q,   shift_d;
    logic        txd_q,     txd_d;

    // The extra pointer MSB tells a wrapped-full FIFO apart from an empty one.
    assign fifoFull  = (wrPtr_q[FIFO_AW] != rdPtr_q[FIFO_AW]) &&
                       (wrPtr_q[FIFO_AW-1:0] == rdPtr_q[FIFO_AW-1:0]);
    assign fifoEmpty = (wrPtr_q == rdPtr_q);
    assign push      = bus.din_valid && !fifoFull;
    assign baudDone  = (baudCnt_q == BAUD_LAST);

    assign bus.full     = fifoFull;
    assign bus.empty    = fifoEmpty;
    assign bus.overflow = overflow_q;
    assign busy         = (state_q != IDLE);
    assign txd          = txd_q;

    // FIFO storage; contents need no reset because the pointers are cleared.
    always_ff @(posedge pclk) begin
        if (!rst && push) begin
            mem_q[wrPtr_q[FIFO_AW-1:0]] <= bus.din;
        end
    end

    // FIFO pointers and the sticky overflow flag (full is judged before any pop).
    always_ff @(posedge pclk) begin
        if (rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + (FIFO_AW+1)'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + (FIFO_AW+1)'(1);
            end
            if (bus.din_valid && fifoFull) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Transmitter state register; txd is registered so din never reaches it combinationally.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q   <= IDLE;
            baudCnt_q <= '0;
            bitIdx_q  <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            baudCnt_q <= baudCnt_d;
            bitIdx_q  <= bitIdx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
        end
    end

    // Next-state logic: frame sequencing, FIFO pops and the next line level.
    always_comb begin
        state_d   = state_q;
        baudCnt_d = baudCnt_q;
        bitIdx_d  = bitIdx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        txd_d     = 1'b1;

        case (state_q)
            IDLE: begin
                if (!fifoEmpty) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rdPtr_q[FIFO_AW-1:0]];
                    baudCnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (baudDone) begin
                    baudCnt_d = '0;
                    bitIdx_d  = '0;
                    state_d   = DATA;
                end else begin
                    baudCnt_d = baudCnt_q + 16'd1;
                end
            end
            DATA: begin
                if (baudDone) begin
                    baudCnt_d = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    if (bitIdx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end else begin
                    baudCnt_d = baudCnt_q + 16'd1;
                end
            end
            STOP: begin
                if (baudDone) begin
                    baudCnt_d = '0;
                    if (!fifoEmpty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rdPtr_q[FIFO_AW-1:0]];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baudCnt_d = baudCnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

endmodule

// File: doc/byte_uart_tx.md
Name: byte_uart_tx

Overview:
- Downstream consumer of the 40-bit-to-byte serializer.
- Accepts the serializer's byte stream on a valid strobe and buffers it in a small synchronous FIFO.
- Emits each byte as an 8N1 asynchronous serial frame (start bit, 8 data bits LSB first, stop bit) on a single line.
- Provides back-pressure status (full) and sticky overflow detection so a 5-byte burst from the serializer is never silently corrupted.

Parameters:
CLKS_PER_BIT, 4, pclk cycles per serial bit; legal range 1..65535
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW (default 8 entries)

Ports:
pclk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
din  input  8  byte from the upstream serializer
din_valid  input  1  din is valid this cycle; one byte per high cycle
full  output  1  FIFO holds 2**FIFO_AW entries
empty  output  1  FIFO holds 0 entries
overflow  output  1  sticky; a write was attempted while full
busy  output  1  transmitter is in a non-IDLE state
txd  output  1  serial line; idles high

Behaviour:
- One clock (pclk). Reset is synchronous and active-high (rst), sampled at the pclk rising edge.
- Reset values: txd=1, busy=0, full=0, empty=1, overflow=0. Pointers, bit counter, baud counter and shift register are cleared.
- Reset mid-frame aborts the frame: txd=1 after that edge, and all buffered bytes are discarded.
- FIFO
  - Read and write pointers are FIFO_AW+1 bits wide.
  - full = MSBs differ and lower bits equal; empty = pointers equal. Both are registered/derived from pointers and valid the cycle after the update.
  - Write occurs when din_valid=1 and full=0 at the edge.
  - If din_valid=1 while full=1, the byte is dropped and overflow is set to 1 until rst. This holds even if a pop happens on the same edge (full is evaluated at start of cycle).
  - A simultaneous push and pop with 0 < occupancy < depth leaves occupancy unchanged.
- Transmit FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1, busy=0. If empty=0, pop the head byte into the shift register, clear the baud counter, and go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: txd=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. After bit 7, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles. On the final cycle:
    - if empty=0, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- The baud counter counts 0..CLKS_PER_BIT-1 and wraps. A state/bit advances when the counter equals CLKS_PER_BIT-1. CLKS_PER_BIT=1 gives one bit per cycle.
- txd is driven from a register, so there is no combinational path from din to txd.
- Latency, with an empty FIFO and IDLE:
  - byte written at edge n;
  - popped at edge n+1;
  - txd falls after edge n+1;
  - frame length is exactly 10*CLKS_PER_BIT cycles.
- Frame payload is bit-exact; byte order is FIFO order.

Test Plan:
- Reset, then one write of din=0x55 at edge 0 (CLKS_PER_BIT=4) -> txd=0 for cycles 1-4. Data bits are 1,0,1,0,1,0,1,0, each held 4 cycles. Stop=1 for cycles 37-40. busy=0 and txd=1 from cycle 41.
- Burst of 0x12, 0x55, 0x66, 0x78, 0x90 on 5 consecutive edges -> 5 contiguous frames totalling 200 cycles. Decoded bytes are in the same order, txd has no idle gap between frames, and overflow stays 0.
- 10 consecutive writes 0x01..0x0A -> 0x01 is popped immediately; full=1 after the 9th write; 0x0A is dropped with overflow=1. Frames carry 0x01..0x09, and empty returns to 1 after the 9th pop.
- Bytes 0x00 and 0xFF -> txd low for 36 consecutive cycles, then stop bit high; for the second frame, start bit low for 4 cycles and then high for 36 cycles.
- Assert rst for 1 cycle during DATA bit 3 with 3 bytes queued -> txd=1, busy=0, empty=1, overflow=0 after the edge. No further frames; the next write starts a fresh frame with 1-cycle latency.
- CLKS_PER_BIT=1 with 0xA5 -> 10-cycle frame: start 0, data 1,0,1,0,0,1,0,1, stop 1.
